// File: rtl/peak_report_pkg.sv
// Shared constants and state encoding for the peak-report sequencer.
package peak_report_pkg;

  localparam logic [7:0] CMD_CH_BASE = 8'h31;
  localparam logic [7:0] CMD_ALL     = 8'h41;
  localparam int         ACK_TIMEOUT = 1024;
  localparam int         NUM_CH      = 4;
  localparam int         TO_WIDTH    = $clog2(ACK_TIMEOUT);

  typedef enum logic [2:0] {
    IDLE,
    SELECT,
    SEND_LO,
    WAIT_LO,
    SEND_HI,
    WAIT_HI
  } state_e;

  // Bytes '1'..'4' select a single channel.
  function automatic logic isChannelCmd(input logic [7:0] cmdByte);
    return (cmdByte >= CMD_CH_BASE) && (cmdByte < CMD_CH_BASE + 8'(NUM_CH));
  endfunction

endpackage

// File: rtl/peak_report_timeout.sv
// Loadable up-counter that flags when the UART acknowledge window has run out.
module peak_report_timeout
  import peak_report_pkg::*;
#(
  parameter int WIDTH = TO_WIDTH,
  parameter int LIMIT = ACK_TIMEOUT
) (
  input  logic             clk_i,
  input  logic             reset_b_i,
  input  logic             clear_i,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_value_i,
  input  logic             enable_i,
  output logic             expired_o
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (load_i) begin
      count_d = load_value_i;
    end else if (enable_i) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!reset_b_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expired_o = (count_q == WIDTH'(LIMIT - 1));

endmodule

// File: rtl/peak_report_ctrl.sv
// Command decoder and sequencer that streams held 16-bit peaks out of the UART,
// low byte first, one channel or all four per command.
module peak_report_ctrl
  import peak_report_pkg::*;
(
  input  logic       clk_i,
  input  logic       reset_b_i,
  input  logic [7:0] rx_data_i,
  input  logic       rx_valid_i,
  input  logic       tx_busy_i,
  output logic       tx_start_o,
  output logic [7:0] channel_sel_o,
  output logic       hold_data_sel_o,
  output logic       byte_to_send_sel_o,
  output logic       busy_o,
  output logic       cmd_error_o,
  output logic       tx_error_o
);

  state_e     state_q;
  logic [7:0] channelSel_q;
  logic       holdSel_q;
  logic       byteSel_q;
  logic       txStart_q;
  logic       busy_q;
  logic       cmdError_q;
  logic       txError_q;
  logic       allMode_q;
  logic       ackSeen_q;

  logic       sending;
  logic       waiting;
  logic       countClear;
  logic       countEnable;
  logic       ackExpired;

  assign sending     = (state_q == SEND_LO) || (state_q == SEND_HI);
  assign waiting     = (state_q == WAIT_LO) || (state_q == WAIT_HI);
  assign countClear  = sending && !tx_busy_i;
  assign countEnable = waiting && !ackSeen_q && !tx_busy_i;

  peak_report_timeout #(
    .WIDTH(TO_WIDTH),
    .LIMIT(ACK_TIMEOUT)
  ) u_timeout (
    .clk_i       (clk_i),
    .reset_b_i   (reset_b_i),
    .clear_i     (countClear),
    .load_i      (1'b0),
    .load_value_i('0),
    .enable_i    (countEnable),
    .expired_o   (ackExpired)
  );

  // WAIT states first see tx_busy rise (ackSeen_q), then wait for it to fall.
  always_ff @(posedge clk_i) begin
    if (!reset_b_i) begin
      state_q      <= IDLE;
      channelSel_q <= 8'd1;
      holdSel_q    <= 1'b0;
      byteSel_q    <= 1'b0;
      txStart_q    <= 1'b0;
      busy_q       <= 1'b0;
      cmdError_q   <= 1'b0;
      txError_q    <= 1'b0;
      allMode_q    <= 1'b0;
      ackSeen_q    <= 1'b0;
    end else begin
      txStart_q  <= 1'b0;
      cmdError_q <= 1'b0;
      txError_q  <= 1'b0;
      if (rx_valid_i && (state_q != IDLE)) begin
        cmdError_q <= 1'b1;
      end
      case (state_q)
        IDLE: begin
          holdSel_q <= 1'b0;
          if (rx_valid_i) begin
            if (isChannelCmd(rx_data_i)) begin
              channelSel_q <= rx_data_i - CMD_CH_BASE + 8'd1;
              allMode_q    <= 1'b0;
              busy_q       <= 1'b1;
              state_q      <= SELECT;
            end else if (rx_data_i == CMD_ALL) begin
              channelSel_q <= 8'd1;
              allMode_q    <= 1'b1;
              busy_q       <= 1'b1;
              state_q      <= SELECT;
            end else begin
              cmdError_q <= 1'b1;
            end
          end
        end
        SELECT: begin
          holdSel_q <= 1'b1;
          byteSel_q <= 1'b0;
          state_q   <= SEND_LO;
        end
        SEND_LO, SEND_HI: begin
          if (!tx_busy_i) begin
            txStart_q <= 1'b1;
            ackSeen_q <= 1'b0;
            state_q   <= (state_q == SEND_LO) ? WAIT_LO : WAIT_HI;
          end
        end
        WAIT_LO, WAIT_HI: begin
          if (!ackSeen_q) begin
            if (tx_busy_i) begin
              ackSeen_q <= 1'b1;
            end else if (ackExpired) begin
              txError_q <= 1'b1;
              busy_q    <= 1'b0;
              holdSel_q <= 1'b0;
              byteSel_q <= 1'b0;
              state_q   <= IDLE;
            end
          end else if (!tx_busy_i) begin
            if (state_q == WAIT_LO) begin
              byteSel_q <= 1'b1;
              state_q   <= SEND_HI;
            end else if (allMode_q && (channelSel_q < 8'(NUM_CH))) begin
              channelSel_q <= channelSel_q + 8'd1;
              holdSel_q    <= 1'b0;
              state_q      <= SELECT;
            end else begin
              busy_q    <= 1'b0;
              holdSel_q <= 1'b0;
              byteSel_q <= 1'b0;
              state_q   <= IDLE;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign tx_start_o         = txStart_q;
  assign channel_sel_o      = channelSel_q;
  assign hold_data_sel_o    = holdSel_q;
  assign byte_to_send_sel_o = byteSel_q;
  assign busy_o             = busy_q;
  assign cmd_error_o        = cmdError_q;
  assign tx_error_o         = txError_q;

endmodule
